// File: rtl/bin_matrix_pkg.sv
// Shared definitions for the binary matrix-vector block: FSM state encoding
// and the reduction-mode constants used on the mode input.
package bin_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_XOR = 1'b0;
    localparam logic MODE_OR  = 1'b1;

endpackage

// File: rtl/bin_dot.sv
// Single-row binary dot product: AND each matrix bit with the matching vector
// bit, then reduce with XOR (GF(2)) or OR (boolean) depending on mode.
module bin_dot
    import bin_matrix_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] row,
    input  logic [N-1:0] vec,
    input  logic         mode,
    output logic         bit_out
);

    logic [N-1:0] prod;

    assign prod    = row & vec;
    assign bit_out = (mode == MODE_OR) ? (|prod) : (^prod);

endmodule

// File: rtl/bin_matvec_seq.sv
// Sequential binary matrix-vector multiply. One operand set is accepted in
// IDLE, rows are computed one per cycle through a single shared bin_dot, and
// the result is held in DONE until the consumer takes it.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for an operand set, in_ready high
// ST_BUSY | computing row row_cnt, busy high; finishes on row N-1
// ST_DONE | result stable on u, out_valid high until out_ready
module bin_matvec_seq
    import bin_matrix_pkg::*;
#(
    parameter int N          = 3,
    parameter bit RESET_MODE = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*N-1:0] a_flat,
    input  logic [N-1:0]   v,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   u,
    output logic           busy
);

    localparam int CW = $clog2(N) + 1;

    state_t           state;
    state_t           state_next;
    logic [N*N-1:0]   a_reg;
    logic [N-1:0]     v_reg;
    logic             mode_reg;
    logic [N-1:0]     u_reg;
    logic [CW-1:0]    row_cnt;
    logic [N-1:0]     a_row;
    logic             dot_bit;
    logic             accept;
    logic             last_row;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign last_row = (row_cnt == CW'(N - 1));
    assign u        = u_reg;

    // Select the registered matrix row addressed by the row counter.
    always_comb begin
        a_row = '0;
        for (int r = 0; r < N; r++) begin
            if (row_cnt == CW'(r)) a_row = a_reg[r*N +: N];
        end
    end

    bin_dot #(.N(N)) u_dot (
        .row     (a_row),
        .vec     (v_reg),
        .mode    (mode_reg),
        .bit_out (dot_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs; outputs are pure functions of state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (last_row) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture on accept, then one result bit written per BUSY cycle.
    // Uncomputed rows stay 0 because u is cleared on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            v_reg    <= '0;
            mode_reg <= RESET_MODE;
            u_reg    <= '0;
            row_cnt  <= '0;
        end else if (accept) begin
            a_reg    <= a_flat;
            v_reg    <= v;
            mode_reg <= mode;
            u_reg    <= '0;
            row_cnt  <= '0;
        end else if (state == ST_BUSY) begin
            for (int r = 0; r < N; r++) begin
                if (row_cnt == CW'(r)) u_reg[r] <= dot_bit;
            end
            row_cnt <= row_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_bin_matvec_seq.sv
// Directed and exhaustive checks of bin_matvec_seq at N=3, plus a random
// regression on an N=8 instance.
module tb_bin_matvec_seq;

    localparam int N = 3;
    localparam int M = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic           in_valid, in_ready, mode, out_valid, out_ready, busy;
    logic [N*N-1:0] a_flat;
    logic [N-1:0]   v, u;

    logic           in_valid_8, in_ready_8, mode_8, out_valid_8, out_ready_8, busy_8;
    logic [M*M-1:0] a_flat_8;
    logic [M-1:0]   v_8, u_8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin_matvec_seq #(.N(N), .RESET_MODE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_flat(a_flat), .v(v), .mode(mode), .out_valid(out_valid),
        .out_ready(out_ready), .u(u), .busy(busy)
    );

    bin_matvec_seq #(.N(M), .RESET_MODE(1'b1)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .a_flat(a_flat_8), .v(v_8), .mode(mode_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .u(u_8), .busy(busy_8)
    );

    typedef struct {
        logic [8:0] a;
        logic [2:0] v;
        logic       mode;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [31:0] model(input logic [1023:0] a, input logic [31:0] vv,
                                          input logic md, input int n);
        logic [31:0] res;
        logic        acc, b;
        res = '0;
        for (int r = 0; r < n; r++) begin
            acc = 1'b0;
            for (int c = 0; c < n; c++) begin
                b   = a[r*n + c] & vv[c];
                acc = md ? (acc | b) : (acc ^ b);
            end
            res[r] = acc;
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run3(input logic [8:0] aa, input logic [2:0] vv, input logic md,
                        input int hold, input logic [2:0] exp, input string name);
        int lat;
        a_flat   = aa;
        v        = vv;
        mode     = md;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 4*N) begin
            step();
            lat++;
        end
        chk({name, "_latency"}, lat, N);
        chk({name, "_u"}, u, exp);
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_release"}, {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run8(input logic [63:0] aa, input logic [7:0] vv, input logic md, input int hold);
        int lat;
        logic [31:0] exp;
        exp         = model(1024'(aa), 32'(vv), md, M);
        a_flat_8    = aa;
        v_8         = vv;
        mode_8      = md;
        in_valid_8  = 1'b1;
        step();
        in_valid_8  = 1'b0;
        lat = 0;
        while (!out_valid_8 && lat < 4*M) begin
            step();
            lat++;
        end
        chk("n8_latency", lat, M);
        chk("n8_u", u_8, exp);
        repeat (hold) step();
        out_ready_8 = 1'b1;
        step();
        out_ready_8 = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_valid;

        tbl[0] = '{9'b100010001, 3'b101, 1'b0, 3'b101};
        tbl[1] = '{9'b111111111, 3'b011, 1'b0, 3'b000};
        tbl[2] = '{9'b111111111, 3'b011, 1'b1, 3'b111};
        tbl[3] = '{9'b000000000, 3'b111, 1'b1, 3'b000};
        tbl[4] = '{9'b110011101, 3'b111, 1'b0, 3'b000};
        tbl[5] = '{9'b110011101, 3'b111, 1'b1, 3'b111};
        tbl[6] = '{9'b110011101, 3'b001, 1'b0, 3'b011};
        tbl[7] = '{9'b110011101, 3'b100, 1'b1, 3'b101};
        tbl[8] = '{9'b001010100, 3'b011, 1'b0, 3'b110};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a_flat = '0; v = '0; mode = 1'b0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b0; a_flat_8 = '0; v_8 = '0; mode_8 = 1'b0;
        repeat (2) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_u", u, 0);

        // Accept on the first edge after release; partial rows read 0.
        a_flat = 9'b100010001; v = 3'b111; mode = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_accept", {busy, in_ready}, 2'b10);
        chk("busy_u_none", u, 3'b000);
        a_flat = '0; v = '0; mode = 1'b0;
        step();
        chk("busy_u_row0", u, 3'b001);
        chk("busy_ignore_in_valid", in_ready, 0);
        step();
        chk("busy_u_row1", u, 3'b011);
        in_valid = 1'b0;
        step();
        chk("done_u", u, 3'b111);
        chk("done_out_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("done_release", {out_valid, in_ready}, 2'b01);

        for (int i = 0; i < 9; i++)
            run3(tbl[i].a, tbl[i].v, tbl[i].mode, i % 3, tbl[i].exp, "table");

        // Backpressure: result held, new operands ignored while DONE.
        a_flat = 9'b111111111; v = 3'b011; mode = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_enter_done", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a_flat = '0; v = 3'($urandom); mode = 1'b0;
            step();
            chk("bp_u_stable", u, 3'b111);
            chk("bp_flags", {out_valid, in_ready, busy}, 3'b100);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release", {out_valid, in_ready}, 2'b01);

        // out_ready held high gives a single-cycle out_valid pulse.
        out_ready = 1'b1;
        a_flat = 9'b100010001; v = 3'b110; mode = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        chk("pulse_valid", out_valid, 1);
        chk("pulse_u", u, 3'b110);
        step();
        chk("pulse_end", {out_valid, in_ready}, 2'b01);
        out_ready = 1'b0;

        // Reset during BUSY row 1 aborts; nothing is delivered afterwards.
        a_flat = 9'b100010001; v = 3'b111; mode = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {out_valid, in_ready, busy}, 3'b010);
        chk("abort_u", u, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        chk("abort_no_result", saw_valid, 0);
        run3(9'b100010001, 3'b101, 1'b0, 1, 3'b101, "after_abort");

        for (int md = 0; md < 2; md++)
            for (int aa = 0; aa < 512; aa++)
                for (int vv = 0; vv < 8; vv++)
                    run3(9'(aa), 3'(vv), md[0], $urandom_range(0, 1),
                         3'(model(1024'(aa), 32'(vv), md[0], N)), "exh");

        for (int i = 0; i < 1000; i++)
            run8({$urandom, $urandom}, 8'($urandom), 1'($urandom), $urandom_range(0, 2));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
